// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, data length and parity mode encodings.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // data_len field encoding: number of data bits minus five
  localparam logic [1:0] LEN_5 = 2'd0;
  localparam logic [1:0] LEN_6 = 2'd1;
  localparam logic [1:0] LEN_7 = 2'd2;
  localparam logic [1:0] LEN_8 = 2'd3;

  // parity mode select, shared with the receive side
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Mask keeping only the data bits that belong to the configured length
  function automatic logic [7:0] len_mask(input logic [1:0] len);
    logic [7:0] m;
    case (len)
      LEN_5:   m = 8'h1F;
      LEN_6:   m = 8'h3F;
      LEN_7:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Parity over the active data bits; odd mode inverts the XOR reduction
  function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] len,
                                       input logic odd);
    return (^(d & len_mask(len))) ^ (odd == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: divisor down-counter producing one bit_tick per bit period.
// Latency: bit_tick is combinational from the counter; first tick div cycles after restart.
// Backpressure: none; restart reloads the counter so the next bit is a full period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;

  // A divisor of zero behaves like one: reload value 0 ticks every cycle
  assign reload = (div == '0) ? '0 : div - DIV_W'(1);

  // Count down to zero, reloading on restart and at every bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign bit_tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them onto txd.
// Latency: pop at cycle N, LOAD at N+1, start bit on txd at N+2; all outputs registered.
// Backpressure: pops only when en and FIFO non-empty and the line is free; never underruns.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       data_len,
  input  logic             par_en,
  input  logic             par_odd,
  input  logic             stop2,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_pop,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);

  tx_state_t        state;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt;
  logic             stop_cnt;
  logic [1:0]       len_q;
  logic             par_en_q;
  logic             par_q;
  logic             stop2_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_sel;
  logic             bit_tick;
  logic             load_st;

  assign load_st = (state == LOAD);

  // The baud counter is restarted in LOAD, the same edge div_q is latched,
  // so it must see the live divisor during that cycle.
  assign div_sel = load_st ? divisor : div_q;

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (load_st),
    .div      (div_sel),
    .bit_tick (bit_tick)
  );

  // Frame FSM with registered line, pop, busy and done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      len_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      div_q    <= '0;
      fifo_pop <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        // IDLE doubles as the pop cycle: a pop issued here or at the end of
        // STOP is followed by LOAD once the FIFO output has updated.
        IDLE: begin
          txd <= 1'b1;
          if (fifo_pop) begin
            fifo_pop <= 1'b0;
            state    <= LOAD;
          end else if (en && !fifo_empty) begin
            fifo_pop <= 1'b1;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          shift_q  <= fifo_dout & len_mask(data_len);
          len_q    <= data_len;
          par_en_q <= par_en;
          par_q    <= calc_parity(fifo_dout, data_len, par_odd);
          stop2_q  <= stop2;
          div_q    <= divisor;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          txd      <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_tick) begin
            txd   <= shift_q[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            // last data bit index is data_len + 4
            if (bit_cnt == {1'b1, len_q}) begin
              if (par_en_q) begin
                txd   <= par_q;
                state <= PARITY;
              end else begin
                txd   <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              txd     <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            txd   <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              tx_done  <= 1'b1;
              stop_cnt <= 1'b0;
              bit_cnt  <= '0;
              state    <= IDLE;
              if (en && !fifo_empty) begin
                fifo_pop <= 1'b1;
              end
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural FIFO feeding it.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] divisor;
  logic [1:0]  data_len;
  logic        par_en;
  logic        par_odd;
  logic        stop2;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_pop;
  logic        txd;
  logic        busy;
  logic        tx_done;

  int total = 0;
  int bad   = 0;

  // behavioural FIFO: registered dout, pushes from the stimulus at negedge
  logic [7:0] mem [0:15];
  int wr_ptr   = 0;
  int rd_ptr   = 0;
  int pop_cnt  = 0;
  int underrun = 0;
  int base;

  assign fifo_empty = (rd_ptr == wr_ptr);

  uart_tx_ctrl #(.DIV_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .divisor    (divisor),
    .data_len   (data_len),
    .par_en     (par_en),
    .par_odd    (par_odd),
    .stop2      (stop2),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_pop) begin
      pop_cnt <= pop_cnt + 1;
      if (fifo_empty) begin
        underrun <= underrun + 1;
      end else begin
        fifo_dout <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at the negedge of the pop cycle. exp[i] is the i-th bit on the line,
  // start bit first. Each bit is checked on every one of its d cycles.
  task automatic check_frame(input string tag, input logic [11:0] exp, input int nbits,
                             input int d);
    int waited;
    waited = 0;
    while (txd !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_latency"}, waited, 2);
    if (waited >= 50) return;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < d; c++) begin
        chk($sformatf("%s_bit%0d_c%0d", tag, i, c), txd, exp[i]);
        if (c == 0) chk($sformatf("%s_nodone%0d", tag, i), tx_done, 0);
        @(negedge clk);
      end
    end
    chk({tag, "_tx_done"}, tx_done, 1);
  endtask

  initial begin
    int waited;
    rst_n    = 1'b0;
    en       = 1'b0;
    divisor  = 16'd4;
    data_len = 2'd3;
    par_en   = 1'b0;
    par_odd  = 1'b0;
    stop2    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_done", tx_done, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    chk("idle_txd", txd, 1);
    chk("idle_busy", busy, 0);

    // 8N1, divisor 4, 0xA5 -> line 0,1,0,1,0,0,1,0,1,1
    push(8'hA5);
    @(negedge clk);
    chk("t1_pop", fifo_pop, 1);
    chk("t1_busy", busy, 1);
    check_frame("t1", 12'b00_11_0100_1010, 10, 4);
    chk("t1_pop_cnt", pop_cnt, 1);
    chk("t1_empty", fifo_empty, 1);
    chk("t1_busy_at_done", busy, 1);
    @(negedge clk);
    chk("t1_done_once", tx_done, 0);
    chk("t1_busy_fall", busy, 0);

    // 7E2, divisor 1, 0x83 -> 0, 1,1,0,0,0,0,0, parity 0, 1,1 (11 cycles)
    data_len = 2'd2; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b1; divisor = 16'd1;
    push(8'h83);
    @(negedge clk);
    chk("t2_pop", fifo_pop, 1);
    check_frame("t2", 12'b0110_0000_0110, 11, 1);
    @(negedge clk);
    chk("t2_busy_fall", busy, 0);

    // 5O1, divisor 2, 0xFF -> 0, 1,1,1,1,1, parity 0, 1
    data_len = 2'd0; par_en = 1'b1; par_odd = 1'b1; stop2 = 1'b0; divisor = 16'd2;
    push(8'hFF);
    @(negedge clk);
    chk("t3_pop", fifo_pop, 1);
    check_frame("t3", 12'b0000_1011_1110, 8, 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t3_idle_txd%0d", k), txd, 1);
    end

    // three queued 8N1 frames, divisor 2: 2-cycle gap after each tx_done
    data_len = 2'd3; par_en = 1'b0; stop2 = 1'b0; divisor = 16'd2;
    base = pop_cnt;
    push(8'h12); push(8'h34); push(8'h56);
    @(negedge clk);
    chk("t4_pop0", fifo_pop, 1);
    check_frame("t4a", {3'b000, 1'b1, 8'h12, 1'b0}, 10, 2);
    chk("t4_pop1", fifo_pop, 1);
    check_frame("t4b", {3'b000, 1'b1, 8'h34, 1'b0}, 10, 2);
    chk("t4_pop2", fifo_pop, 1);
    check_frame("t4c", {3'b000, 1'b1, 8'h56, 1'b0}, 10, 2);
    chk("t4_no_pop_empty", fifo_pop, 0);
    repeat (5) @(negedge clk);
    chk("t4_pop_cnt", pop_cnt, base + 3);
    chk("t4_busy", busy, 0);

    // config change and en drop mid-frame leave the 8N1 frame intact
    divisor = 16'd3;
    base = pop_cnt;
    push(8'h5A);
    @(negedge clk);
    chk("t5_pop", fifo_pop, 1);
    fork
      check_frame("t5", {3'b000, 1'b1, 8'h5A, 1'b0}, 10, 3);
      begin
        repeat (8) @(negedge clk);
        data_len = 2'd0;
        par_en   = 1'b1;
        en       = 1'b0;
        push(8'h77);
      end
    join
    repeat (6) @(negedge clk);
    chk("t5_pop_cnt", pop_cnt, base + 1);
    chk("t5_fifo_kept", fifo_empty, 0);
    chk("t5_busy", busy, 0);

    // reset during DATA: txd high at once, then clean IDLE
    data_len = 2'd3; par_en = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("t6_pop", fifo_pop, 1);
    waited = 0;
    while (txd !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("t6_latency", waited, 2);
    repeat (12) @(negedge clk);
    chk("t6_data_bit3", txd, 0);
    chk("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_txd", txd, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pop", fifo_pop, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = pop_cnt;
    repeat (3) @(negedge clk);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_txd", txd, 1);
    chk("t6_post_pops", pop_cnt, base);
    divisor = 16'd1;
    push(8'h3C);
    @(negedge clk);
    chk("t6_new_pop", fifo_pop, 1);
    check_frame("t6", {3'b000, 1'b1, 8'h3C, 1'b0}, 10, 1);

    chk("underrun", underrun, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side serializer that drains the UART TX FIFO (`fifo_uart` instance) and drives the serial line. Pops one byte whenever the FIFO is non-empty and the line is idle. Frames the byte as start + 5..8 data bits (LSB first) + optional parity + 1 or 2 stop bits, at a bit rate set by a programmable clock divisor. Sits directly downstream of the TX FIFO and upstream of the pad.

## Interface
Parameters:
- `DIV_W`, 16, width of the baud divisor.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  transmitter enable; gates frame start only.
- `divisor`  in  DIV_W  clk cycles per bit; 0 is treated as 1.
- `data_len`  in  2  data bits − 5 (0 → 5 bits, 3 → 8 bits).
- `par_en`  in  1  parity bit enable.
- `par_odd`  in  1  1 = odd parity, 0 = even parity.
- `stop2`  in  1  1 = two stop bits.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_dout`  in  8  FIFO `dout`; registered, valid the cycle after a pop.
- `fifo_pop`  out  1  one-cycle pop pulse to FIFO `pop_in`.
- `txd`  out  1  serial line; idle high.
- `busy`  out  1  high from pop through the last stop bit.
- `tx_done`  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- FSM states: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: `txd`=1, `busy`=0. If `en` & !`fifo_empty`: pulse `fifo_pop`, go to LOAD.
- LOAD (1 cycle): capture `fifo_dout` into the shift register. Latch `data_len`, `par_en`, `par_odd`, `stop2` and `divisor` into frame registers. Compute parity as XOR of the first `data_len`+5 bits, inverted if odd. Go to START.
- START: `txd`=0 for one bit period, then go to DATA.
- DATA: `txd`=shift[0]; shift right at each bit end. After `data_len`+5 bits, go to PARITY if `par_en`, else STOP.
- PARITY: `txd`=parity for one bit period, then go to STOP.
- STOP: `txd`=1 for 1 or 2 bit periods.
  - At the end of the stop bits, pulse `tx_done`.
  - If `en` & !`fifo_empty` at that point, pulse `fifo_pop` in the same cycle and go to LOAD (back-to-back frames). Otherwise go to IDLE.
- Config changes and `en` deassertion mid-frame do not affect the frame in flight. The frame completes using the latched values.
- `fifo_pop` is never asserted while `fifo_empty`=1, so FIFO underrun cannot occur.
- Bit counter width is 3 bits. Data bits are unused above the latched length (upper bits of `fifo_dout` are ignored for 5–7 bit modes).

## Timing
- Reset values: `txd`=1, `fifo_pop`=0, `busy`=0, `tx_done`=0, FSM=IDLE, all counters 0.
- Reset mid-frame: `txd` returns to 1 immediately (asynchronously); the partial frame is abandoned and the byte is lost.
- All outputs are registered.
- Pop-to-start-bit latency: `fifo_pop` at cycle N, LOAD at N+1, `txd` falls at N+2.
- Bit period: exactly max(`divisor`,1) clk cycles. The divisor counter reloads at each bit boundary.
- Frame length in bits: 1 + (`data_len`+5) + `par_en` + (1+`stop2`).
- Back-to-back frames: the gap between the last stop bit end and the next start bit is 2 clk cycles (pop, LOAD).
- `busy` rises in the pop cycle and falls the cycle after `tx_done` if no next frame starts.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `tx_state_t`.
  - Data length encoding constants.
  - Parity mode constants (shared with the RX side).
- Sub-module `uart_baud_gen`: divisor down-counter with a synchronous restart input and a `bit_tick` output. Restart is asserted on LOAD so that the first bit is a full period.
- Everything else (FSM, shift register, parity, bit counter) lives in `uart_tx_ctrl`.

## Test plan
- Reset, `divisor`=4, 8N1, push 0xA5 into FIFO → one `fifo_pop`; `txd` = 0,1,0,1,0,0,1,0,1,1 with each bit lasting 4 cycles; `tx_done` pulses once; FIFO is empty afterwards.
- 7E2, `divisor`=1, byte 0x83 → 7 data bits 1,1,0,0,0,0,0, parity 0, two stop bits; frame is 11 cycles.
- 5O1, byte 0xFF → data 1,1,1,1,1, parity 0, upper 3 bits never appear on `txd`.
- Three bytes queued, `en`=1 → three frames, each new start bit exactly 2 cycles after the previous `tx_done`; no pop while `fifo_empty`.
- Change `data_len` and deassert `en` mid-frame → current frame unchanged; no further pop.
- Assert `rst_n`=0 during DATA → `txd`=1 immediately; after release, the FSM is in IDLE and `busy`=0.
